// File: rtl/dmem_store_buffer_pkg.sv
// rtl/dmem_store_buffer_pkg.sv - shared widths, depth and state encodings for the store buffer
package dmem_store_buffer_pkg;

    localparam int WORD_LEN = 32;
    localparam int STRB_LEN = 4;
    localparam int SB_DEPTH = 4;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_DRAIN = 2'd1,
        SB_FLUSH = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// rtl/sb_fwd_merge.sv - youngest-first per-byte merge of matching store entries
module sb_fwd_merge
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic [DEPTH-1:0]               i_match,
    input  logic [DEPTH-1:0][WORD_LEN-1:0] i_data,
    input  logic [DEPTH-1:0][STRB_LEN-1:0] i_strb,
    output logic [WORD_LEN-1:0]            o_data,
    output logic [STRB_LEN-1:0]            o_mask
);

    // Index 0 is the oldest entry; later (younger) matches overwrite earlier lanes.
    always_comb begin
        o_data = '0;
        o_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_match[k]) begin
                for (int b = 0; b < STRB_LEN; b++) begin
                    if (i_strb[k][b]) begin
                        o_data[8*b +: 8] = i_data[k][8*b +: 8];
                        o_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - in-order store FIFO draining to memory; STORE_FWD_EN adds load forwarding
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [WORD_LEN-1:0] st_addr,
    input  logic [WORD_LEN-1:0] st_wdata,
    input  logic [STRB_LEN-1:0] st_wstrb,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_addr_w,
    output logic [WORD_LEN-1:0] mem_wdata,
    output logic [STRB_LEN-1:0] mem_wstrb,
    input  logic                mem_wack,
    input  logic [WORD_LEN-1:0] ld_addr,
    output logic                fwd_hit,
    output logic [WORD_LEN-1:0] fwd_data,
    output logic [STRB_LEN-1:0] fwd_mask,
    input  logic                flush_req,
    output logic                flush_done,
    output logic                empty,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = CNT_W - 1;

    logic [WORD_LEN-1:2] r_addr [DEPTH];
    logic [WORD_LEN-1:0] r_data [DEPTH];
    logic [STRB_LEN-1:0] r_strb [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_empty;
    logic                r_flush_done;
    sb_state_t           r_state;
    sb_state_t           w_state_next;
    logic                w_flush_done_next;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count_next;
    logic                w_unused;

    // Ready depends only on registered state so memory ack never reaches the core combinationally.
    assign st_ready = (r_count != CNT_W'(DEPTH)) && (r_state != SB_FLUSH);
    assign mem_wen  = (r_count != '0);
    assign w_push   = st_valid && st_ready;
    assign w_pop    = mem_wen && mem_wack;

    assign mem_addr_w = mem_wen ? {r_addr[r_head], 2'b00} : '0;
    assign mem_wdata  = mem_wen ? r_data[r_head] : '0;
    assign mem_wstrb  = mem_wen ? r_strb[r_head] : '0;
    assign count      = r_count;
    assign empty      = r_empty;
    assign flush_done = r_flush_done;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Next state; a flush that finds the buffer already drained completes without entering FLUSH.
    always_comb begin
        w_state_next      = r_state;
        w_flush_done_next = 1'b0;
        case (r_state)
            SB_IDLE, SB_DRAIN: begin
                if (flush_req) begin
                    if (w_count_next == '0) begin
                        w_state_next      = SB_IDLE;
                        w_flush_done_next = 1'b1;
                    end else begin
                        w_state_next = SB_FLUSH;
                    end
                end else if (w_count_next != '0) begin
                    w_state_next = SB_DRAIN;
                end else begin
                    w_state_next = SB_IDLE;
                end
            end
            SB_FLUSH: begin
                if (w_count_next == '0) begin
                    w_state_next      = SB_IDLE;
                    w_flush_done_next = 1'b1;
                end
            end
            default: w_state_next = SB_IDLE;
        endcase
    end

    // Control registers; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SB_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_empty      <= (w_count_next == '0);
            r_flush_done <= w_flush_done_next;
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
        end
    end

    // Entry storage; contents are only observed while counted as valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr[WORD_LEN-1:2];
            r_data[r_tail] <= st_wdata;
            r_strb[r_tail] <= st_wstrb;
        end
    end

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0]               w_fwd_match;
    logic [DEPTH-1:0][WORD_LEN-1:0] w_age_data;
    logic [DEPTH-1:0][STRB_LEN-1:0] w_age_strb;

    // Re-order entries oldest-to-youngest starting at head and word-compare each valid one.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        w_fwd_match = '0;
        w_age_data  = '0;
        w_age_strb  = '0;
        v_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx          = r_head + PTR_W'(k);
            w_age_data[k]  = r_data[v_idx];
            w_age_strb[k]  = r_strb[v_idx];
            w_fwd_match[k] = (CNT_W'(k) < r_count) &&
                             (r_addr[v_idx] == ld_addr[WORD_LEN-1:2]);
        end
    end

    sb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd_merge (
        .i_match (w_fwd_match),
        .i_data  (w_age_data),
        .i_strb  (w_age_strb),
        .o_data  (fwd_data),
        .o_mask  (fwd_mask)
    );

    assign fwd_hit  = |fwd_mask;
    assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign fwd_mask = '0;
    assign w_unused = ^{st_addr[1:0], ld_addr};
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed scoreboard bench for dmem_store_buffer
module tb_dmem_store_buffer;
    import dmem_store_buffer_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                st_valid = 1'b0;
    logic                st_ready;
    logic [WORD_LEN-1:0] st_addr = '0;
    logic [WORD_LEN-1:0] st_wdata = '0;
    logic [STRB_LEN-1:0] st_wstrb = '0;
    logic                mem_wen;
    logic [WORD_LEN-1:0] mem_addr_w;
    logic [WORD_LEN-1:0] mem_wdata;
    logic [STRB_LEN-1:0] mem_wstrb;
    logic                mem_wack = 1'b0;
    logic [WORD_LEN-1:0] ld_addr = '0;
    logic                fwd_hit;
    logic [WORD_LEN-1:0] fwd_data;
    logic [STRB_LEN-1:0] fwd_mask;
    logic                flush_req = 1'b0;
    logic                flush_done;
    logic                empty;
    logic [2:0]          count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    dmem_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .mem_wen    (mem_wen),
        .mem_addr_w (mem_addr_w),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_wack   (mem_wack),
        .ld_addr    (ld_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .fwd_mask   (fwd_mask),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic acc);
        wr_t e;
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_wstrb = s;
        chk("st_ready_at_store", {31'd0, st_ready}, {31'd0, acc});
        if (acc) begin
            e.addr = {a[31:2], 2'b00};
            e.data = d;
            e.strb = s;
            sb_q.push_back(e);
        end
        tick();
        st_valid = 1'b0;
    endtask

    // Scoreboard: every accepted memory write must match the oldest expected store.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_wen && mem_wack) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", mem_addr_w, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wr_strb", {28'd0, mem_wstrb}, {28'd0, e.strb});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) tick();
        chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_addr", mem_addr_w, 32'd0);
        chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
        chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single store with ack high
        mem_wack = 1'b1;
        store(32'h100, 32'hDEADBEEF, 4'hF, 1'b1);
        chk("single_wen", {31'd0, mem_wen}, 32'd1);
        chk("single_addr", mem_addr_w, 32'h100);
        chk("single_count1", {29'd0, count}, 32'd1);
        chk("single_empty0", {31'd0, empty}, 32'd0);
        tick();
        chk("single_count0", {29'd0, count}, 32'd0);
        chk("single_empty1", {31'd0, empty}, 32'd1);
        chk("idle_wen", {31'd0, mem_wen}, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        chk("idle_wstrb", {28'd0, mem_wstrb}, 32'd0);

        // Fill with ack low, then a 5th store while full and popping is rejected
        mem_wack = 1'b0;
        for (int i = 0; i < 4; i++)
            store(32'h301 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1), 1'b1);
        chk("full_st_ready", {31'd0, st_ready}, 32'd0);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_head_addr", mem_addr_w, 32'h300);
        mem_wack = 1'b1;
        store(32'h400, 32'h5555_5555, 4'hF, 1'b0);
        chk("drain_count3", {29'd0, count}, 32'd3);
        tick();
        chk("drain_count2", {29'd0, count}, 32'd2);
        chk("drain_wen", {31'd0, mem_wen}, 32'd1);
        tick();
        chk("drain_count1", {29'd0, count}, 32'd1);
        tick();
        chk("drain_count0", {29'd0, count}, 32'd0);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Flush with 3 queued entries
        mem_wack = 1'b0;
        for (int i = 0; i < 3; i++)
            store(32'h500 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("flush_ready_blk0", {31'd0, st_ready}, 32'd0);
        chk("flush_done_early0", {31'd0, flush_done}, 32'd0);
        tick();
        chk("flush_ready_blk1", {31'd0, st_ready}, 32'd0);
        mem_wack = 1'b1;
        tick();
        chk("flush_count2", {29'd0, count}, 32'd2);
        chk("flush_ready_blk2", {31'd0, st_ready}, 32'd0);
        chk("flush_done_early1", {31'd0, flush_done}, 32'd0);
        tick();
        chk("flush_count1", {29'd0, count}, 32'd1);
        chk("flush_ready_blk3", {31'd0, st_ready}, 32'd0);
        tick();
        chk("flush_done_pulse", {31'd0, flush_done}, 32'd1);
        chk("flush_empty", {31'd0, empty}, 32'd1);
        chk("flush_ready_back", {31'd0, st_ready}, 32'd1);
        tick();
        chk("flush_done_end", {31'd0, flush_done}, 32'd0);

        // Flush while already empty
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("flush_empty_pulse", {31'd0, flush_done}, 32'd1);
        chk("flush_empty_ready", {31'd0, st_ready}, 32'd1);
        tick();
        chk("flush_empty_end", {31'd0, flush_done}, 32'd0);

        // Forwarding lookup with two overlapping stores held in the buffer
        mem_wack = 1'b0;
        store(32'h200, 32'h1122_3344, 4'hF, 1'b1);
        store(32'h200, 32'h0000_AA00, 4'h2, 1'b1);
        ld_addr = 32'h200;
        #1;
`ifdef STORE_FWD_EN
        chk("fwd_hit", {31'd0, fwd_hit}, 32'd1);
        chk("fwd_mask", {28'd0, fwd_mask}, 32'hF);
        chk("fwd_data", fwd_data, 32'h1122_AA44);
        ld_addr = 32'h204;
        #1;
        chk("fwd_miss_hit", {31'd0, fwd_hit}, 32'd0);
        chk("fwd_miss_mask", {28'd0, fwd_mask}, 32'd0);
`else
        chk("nofwd_hit", {31'd0, fwd_hit}, 32'd0);
        chk("nofwd_mask", {28'd0, fwd_mask}, 32'd0);
        chk("nofwd_data", fwd_data, 32'd0);
`endif
        ld_addr = 32'h0;
        mem_wack = 1'b1;
        tick();
        tick();
        chk("fwd_drained", {31'd0, empty}, 32'd1);

        // Reset in the middle of a drain
        mem_wack = 1'b0;
        store(32'h700, 32'hC0DE_0001, 4'hF, 1'b1);
        store(32'h704, 32'hC0DE_0002, 4'hF, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_wen", {31'd0, mem_wen}, 32'd0);
        chk("rstmid_count", {29'd0, count}, 32'd0);
        chk("rstmid_ready", {31'd0, st_ready}, 32'd1);
        chk("rstmid_empty", {31'd0, empty}, 32'd1);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        mem_wack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstmid_no_write", {31'd0, mem_wen}, 32'd0);
        end

        // Ten back-to-back stores with ack high: pointers wrap, occupancy stays at one
        mem_wack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            store(32'h800 + 32'(i * 4), $urandom, (i == 5) ? 4'h0 : 4'hF, 1'b1);
            st_valid = (i != 9);
            chk("wrap_count", {29'd0, count}, 32'd1);
            chk("wrap_wen", {31'd0, mem_wen}, 32'd1);
        end
        st_valid = 1'b0;
        tick();
        chk("wrap_count_end", {29'd0, count}, 32'd0);
        chk("wrap_empty_end", {31'd0, empty}, 32'd1);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
